// File: rtl/oam_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_pkg
//  Description : Shared constants, state encoding and echo-page remap used
//                by the FF46 OAM DMA engine.
//  Revision    : 1.0  initial release
// ============================================================================
package oam_dma_pkg;

    // Defaults for the DMA register location, OAM base and transfer size
    localparam logic [15:0] c_REG_ADDR    = 16'hFF46;
    localparam logic [15:0] c_DST_BASE    = 16'hFE00;
    localparam int          c_LENGTH      = 160;
    localparam int          c_START_DELAY = 1;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } dma_state_t;

    // Pages E0-FF are the echo of C0-DF; fold them back onto work RAM
    function automatic logic [7:0] echo_remap(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - 8'h20) : page;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma
//  Description : OAM DMA engine. A CPU write to the DMA register latches a
//                source page and copies LENGTH bytes from page:00 into OAM,
//                one byte per step_en tick, flagging `active` throughout.
//  Revision    : 1.0  initial release
// ============================================================================
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] REG_ADDR    = c_REG_ADDR,
    parameter logic [15:0] DST_BASE    = c_DST_BASE,
    parameter int          LENGTH      = c_LENGTH,
    parameter int          START_DELAY = c_START_DELAY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_write_enable,
    output logic [7:0]  cpu_data_r,
    input  logic        step_en,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data_r,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_data_w,
    output logic        oam_write_enable,
    output logic        active
);

    // Index of the final byte and the reload value for the start delay
    localparam logic [7:0] c_LAST  = 8'(LENGTH - 1);
    localparam logic [7:0] c_DELAY = 8'(START_DELAY);

    dma_state_t  r_state;
    dma_state_t  w_state_next;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [7:0]  w_index_next;
    logic [7:0]  r_delay;
    logic [7:0]  w_delay_next;
    logic        w_capture;
    logic        w_reg_write;
    logic        r_live;
    logic [15:0] r_oam_addr;
    logic [7:0]  r_oam_data;
    logic        r_oam_we;

    assign w_reg_write = cpu_write_enable && (cpu_addr == REG_ADDR);

    // Source read address is always the current page/index pair
    assign src_addr = {echo_remap(r_page), r_index};

    // Readback is held at zero while in reset; unmapped addresses read FF
    assign cpu_data_r = !r_live                 ? 8'h00  :
                        (cpu_addr == REG_ADDR)  ? r_page : 8'hFF;

    assign active           = (r_state != IDLE);
    assign oam_addr         = r_oam_addr;
    assign oam_data_w       = r_oam_data;
    assign oam_write_enable = r_oam_we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, index/delay update and capture decision; a register write overrides everything
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_delay_next = r_delay;
        w_capture    = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_next = IDLE;
            end
            START: begin
                if (step_en) begin
                    // The tick that exhausts the delay also enters XFER so
                    // the first byte is read on the following tick
                    if (r_delay <= 8'd1) begin
                        w_delay_next = 8'd0;
                        w_state_next = XFER;
                    end else begin
                        w_delay_next = r_delay - 8'd1;
                    end
                end
            end
            XFER: begin
                if (step_en) begin
                    w_capture    = 1'b1;
                    w_index_next = r_index + 8'd1;
                    if (r_index == c_LAST) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_reg_write) begin
            w_state_next = START;
            w_index_next = 8'd0;
            w_delay_next = c_DELAY;
            w_capture    = 1'b0;
        end
    end

    // Datapath registers: page latch, counters and the one-clock OAM write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page     <= 8'h00;
            r_index    <= 8'd0;
            r_delay    <= 8'd0;
            r_live     <= 1'b0;
            r_oam_we   <= 1'b0;
            r_oam_addr <= DST_BASE;
            r_oam_data <= 8'h00;
        end else begin
            r_live   <= 1'b1;
            r_index  <= w_index_next;
            r_delay  <= w_delay_next;
            r_oam_we <= w_capture;
            if (w_reg_write) begin
                r_page <= cpu_data_w;
            end
            if (w_capture) begin
                r_oam_data <= src_data_r;
                r_oam_addr <= DST_BASE + {8'h00, r_index};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine for the FF46 register.
- A CPU write to FF46 latches a source page and starts a copy of LENGTH bytes from the page base (XX00) into the OAM local memory at FE00.
- It sits between the CPU bus decoder and the OAM lram instance: it drives the source-memory read port and the OAM write port, and flags `active` so the bus arbiter can lock the CPU out of non-HRAM space.

Parameters:
- REG_ADDR, 'hFF46, absolute address of the DMA register
- DST_BASE, 'hFE00, absolute base address of OAM
- LENGTH, 160, bytes per transfer
- START_DELAY, 1, step_en ticks between the register write and the first source read

Ports:
- clk  in  1  system clock (one clock domain)
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU absolute address
- cpu_data_w  in  8  CPU write data
- cpu_write_enable  in  1  CPU write strobe
- cpu_data_r  out  8  register readback, valid when cpu_addr==REG_ADDR
- step_en  in  1  one-clk pacing pulse (M-cycle tick); all transfer progress happens only on clk edges where step_en=1
- src_addr  out  16  absolute address for source-memory read
- src_data_r  in  8  source read data; valid before the posedge that ends the cycle in which src_addr was presented (negedge-read memories)
- oam_addr  out  16  absolute OAM address (DST_BASE+index)
- oam_data_w  out  8  byte to write into OAM
- oam_write_enable  out  1  OAM write strobe, one clk wide
- active  out  1  high from the register write until the last OAM write completes

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; page register=8'h00; index=0; delay counter=0.
  - Outputs: active=0, oam_write_enable=0, src_addr=16'h0000, oam_addr=DST_BASE, oam_data_w=8'h00, cpu_data_r=8'h00.
- Register write (posedge with cpu_write_enable=1 and cpu_addr==REG_ADDR), independent of step_en:
  - page <= cpu_data_w; index <= 0; delay <= START_DELAY; state <= START; active <= 1.
  - A write during START or XFER restarts the transfer. A pending OAM write in that same edge is suppressed.
- cpu_data_r always returns the last written page, including during a transfer. It returns 8'hFF when cpu_addr!=REG_ADDR.
- Source mapping: effective page = page when page<8'hE0, else page-8'h20 (echo RAM E0-FF maps to C0-DF). src_addr = {eff_page, index[7:0]}.
- States:
  - IDLE: active=0, no writes. Leaves only on a register write.
  - START: on each step_en, delay decrements; at delay==0 with step_en, go to XFER.
  - XFER: src_addr is presented combinationally from index. On a step_en edge:
    - Capture src_data_r into oam_data_w, set oam_addr=DST_BASE+index, pulse oam_write_enable for exactly the next clk.
    - index increments.
    - When index==LENGTH-1 at that edge, go to DRAIN.
  - DRAIN: the final write pulse is issued. Next clk: state=IDLE, active=0.
- Latency: write at edge T with step_en every clk and START_DELAY=1 gives:
  - first oam_write_enable during clk T+2;
  - last during T+1+LENGTH;
  - active falls at edge T+2+LENGTH.
- step_en low stalls all progress. oam_write_enable is never high for more than one clk per byte.
- Width rules: index is 8 bits, and LENGTH ≤ 256 is required. DST_BASE+index is a 16-bit add with no wrap for the defaults.
- A simultaneous register write and last-byte edge: the restart wins; no DRAIN.
- Reset mid-transfer aborts immediately; OAM keeps the bytes already written.

Decomposition:
- Shared package holds:
  - the REG_ADDR, DST_BASE and LENGTH defaults;
  - the state enum (IDLE, START, XFER, DRAIN);
  - a function for the echo-page remap.
- No sub-module is needed.
- Top-level integration instantiates oam_dma beside the OAM lram, with a mux on OAM address/data/write_enable selected by `active`.

Test Plan:
- Write 8'hC0 to FF46, step_en=1 constant, source memory holds byte i = i^8'h5A at C000+i:
  - exactly 160 oam_write_enable pulses at FE00..FE9F with data i^8'h5A;
  - active is high for 162 clks.
- Write 8'hE3: src_addr sequence C300..C39F. Readback of FF46 = 8'hE3 throughout.
- step_en every 4th clk: writes are spaced 4 clks apart; the total transfer spans START_DELAY+160 step_en ticks.
- Restart: write 8'hC0, then at byte 50 write 8'hD0:
  - no further C0xx reads;
  - next write lands at FE00 with D000 data;
  - 160 writes follow.
- Assert rst_n=0 at byte 80:
  - active, oam_write_enable and cpu_data_r drop to 0 immediately (async);
  - no writes after release until a new FF46 write.
- Write to FF47, and read FF46 with no write: no transfer starts; cpu_data_r=8'hFF at FF47.
